// File: rtl/vga_pixel_fetch_if.sv
// BRAM read port between the pixel fetcher (master) and the frame-buffer RAM (slave).
interface vga_pixel_fetch_if #(
    parameter int unsigned ADDR_W = 20
);
    logic [ADDR_W-1:0] bram_addr_o;
    logic              bram_rd_o;
    logic [7:0]        bram_dout_i;

    modport master (output bram_addr_o, output bram_rd_o, input bram_dout_i);
    modport slave  (input bram_addr_o, input bram_rd_o, output bram_dout_i);
endinterface

// File: rtl/vga_pixel_fetch.sv
// Double-buffered frame-buffer reader: turns the timing stage's per-pixel strobe into
// BRAM reads and realigns the returned bytes into the rgb stream.
module vga_pixel_fetch #(
    parameter int unsigned IMG_W     = 540,
    parameter int unsigned IMG_H     = 540,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BRAM_LAT  = 1,
    parameter int unsigned BUF1_BASE = 291600
) (
    input  logic                   clk_65,
    input  logic                   rst_n,
    input  logic                   vga_vs_i,
    input  logic                   bram_en_i,
    input  logic                   frame_done_i,
    vga_pixel_fetch_if.master      bram,
    output logic [7:0]             rgb_o,
    output logic                   rgb_valid_o,
    output logic                   rd_buf_o,
    output logic                   swap_ack_o,
    output logic                   ovf_err_o,
    output logic                   unf_err_o
);
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned IDX_W = $clog2(NPIX + 1);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] ACTIVE   = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                vs_q, vs_d;
    logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
    logic                pend_q, pend_d;
    logic                rd_buf_q, rd_buf_d;
    logic                ack_q, ack_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [BRAM_LAT-1:0] vld_q, vld_d;
    logic [7:0]          rgb_q, rgb_d;
    logic                rgb_vld_q, rgb_vld_d;
    logic                sof_c;

    assign sof_c = vs_q & ~vga_vs_i;

    always_comb begin
        state_d   = state_q;
        vs_d      = vga_vs_i;
        pix_idx_d = pix_idx_q;
        pend_d    = pend_q;
        rd_buf_d  = rd_buf_q;
        ack_d     = 1'b0;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        vld_d     = BRAM_LAT'({vld_q, rd_q});
        rgb_vld_d = vld_q[BRAM_LAT-1];
        rgb_d     = vld_q[BRAM_LAT-1] ? bram.bram_dout_i : 8'd0;

        // Frame start wins over a coincident strobe; swap lands before the strobe's base is chosen.
        if (sof_c) begin
            state_d   = ACTIVE;
            pix_idx_d = '0;
            if (state_q == ACTIVE && pix_idx_q < IDX_W'(NPIX)) begin
                unf_d = 1'b1;
            end
            if (pend_q) begin
                rd_buf_d = ~rd_buf_q;
                pend_d   = 1'b0;
                ack_d    = 1'b1;
            end
        end

        // A request arriving on the SOF cycle waits for the next frame start.
        if (frame_done_i) begin
            pend_d = 1'b1;
        end

        if (state_d == ACTIVE && bram_en_i) begin
            if (pix_idx_d < IDX_W'(NPIX)) begin
                rd_d      = 1'b1;
                addr_d    = (rd_buf_d ? ADDR_W'(BUF1_BASE) : ADDR_W'(0)) + ADDR_W'(pix_idx_d);
                pix_idx_d = pix_idx_d + IDX_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_65) begin
        if (!rst_n) begin
            state_q   <= WAIT_SOF;
            vs_q      <= 1'b1;
            pix_idx_q <= '0;
            pend_q    <= 1'b0;
            rd_buf_q  <= 1'b0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            vld_q     <= '0;
            rgb_q     <= 8'd0;
            rgb_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vs_d;
            pix_idx_q <= pix_idx_d;
            pend_q    <= pend_d;
            rd_buf_q  <= rd_buf_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            vld_q     <= vld_d;
            rgb_q     <= rgb_d;
            rgb_vld_q <= rgb_vld_d;
        end
    end

    assign bram.bram_addr_o = addr_q;
    assign bram.bram_rd_o   = rd_q;
    assign rgb_o            = rgb_q;
    assign rgb_valid_o      = rgb_vld_q;
    assign rd_buf_o         = rd_buf_q;
    assign swap_ack_o       = ack_q;
    assign ovf_err_o        = ovf_q;
    assign unf_err_o        = unf_q;
endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Upstream feeder for the VGA timing/output stage. Consumes that stage's per-pixel read strobe and active-low VSYNC, generates BRAM read addresses for a 540x540 8-bit grayscale image, and realigns BRAM read data into an 8-bit pixel stream returned as that stage's rgb input. Double-buffered: displays one frame buffer while an image writer fills the other; buffer swaps occur only at frame start.

Parameters:
IMG_W, 540, image width in pixels
IMG_H, 540, image height in lines
ADDR_W, 20, BRAM address width; must hold 2*IMG_W*IMG_H-1
BRAM_LAT, 1, BRAM read latency in cycles; legal values 1 or 2
BUF1_BASE, 291600, base address of buffer 1; buffer 0 base is 0

Ports:
clk_65  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
vga_vs_i  in  1  VSYNC from the timing stage, active low
bram_en_i  in  1  per-pixel read strobe from the timing stage
frame_done_i  in  1  one-cycle pulse from the writer: back buffer complete, request swap
bram_addr_o  out  ADDR_W  BRAM read address
bram_rd_o  out  1  BRAM read enable
bram_dout_i  in  8  BRAM read data, valid BRAM_LAT cycles after bram_rd_o
rgb_o  out  8  pixel data to the timing stage
rgb_valid_o  out  1  rgb_o carries fetched data
rd_buf_o  out  1  buffer currently displayed; the writer targets ~rd_buf_o
swap_ack_o  out  1  one-cycle pulse when a swap takes effect
ovf_err_o  out  1  sticky: strobe received after the frame's last pixel
unf_err_o  out  1  sticky: frame ended with fewer than IMG_W*IMG_H reads

Behaviour:
- Reset (rst_n=0 at a clk_65 edge): all outputs 0, rd_buf_o=0, pix_idx=0, swap_pending=0, vs_d=1, data-valid pipeline cleared, FSM=WAIT_SOF.
- Frame start (SOF) is vs_d==1 && vga_vs_i==0, where vs_d is vga_vs_i registered.
- FSM:
  - WAIT_SOF: bram_en_i is ignored, with no reads and no error flags. On SOF, go to ACTIVE, pix_idx=0.
  - ACTIVE: On SOF, check unf_err: set it if pix_idx < IMG_W*IMG_H. Then set pix_idx=0 and apply any pending swap. Remain in ACTIVE.
- Swap: frame_done_i sets swap_pending.
  - On SOF with swap_pending=1: toggle rd_buf_o, clear swap_pending, pulse swap_ack_o for the same cycle the new rd_buf_o appears.
  - frame_done_i coincident with SOF is not applied at that SOF; it remains pending for the next SOF.
  - Repeated frame_done_i while pending has no extra effect.
  - Swap applies in WAIT_SOF too, at the first SOF.
- Address path: 1-cycle registered. In ACTIVE with bram_en_i=1 and pix_idx < IMG_W*IMG_H:
  - next cycle: bram_rd_o=1, bram_addr_o = base(rd_buf_o) + pix_idx, computed ADDR_W bits wide with no wrap.
  - pix_idx increments.
- Overflow: bram_en_i=1 with pix_idx == IMG_W*IMG_H gives no read, holds pix_idx, and sets ovf_err_o.
- When bram_rd_o=0, bram_addr_o holds its last value.
- SOF and bram_en_i in the same cycle: SOF has priority. pix_idx restarts at 0, the strobe is issued as pixel 0 of the new frame, and base uses the post-swap rd_buf_o.
- Data path: a valid shift register of depth BRAM_LAT tracks bram_rd_o.
  - When the valid tap is 1: rgb_o <= bram_dout_i registered, rgb_valid_o=1.
  - Otherwise rgb_o=0, rgb_valid_o=0.
  - Total latency from bram_en_i to rgb_o: BRAM_LAT+2 cycles. The timing stage window is offset accordingly.
- Error flags clear only on reset.
- Reset mid-frame: the next cycle is WAIT_SOF. Reads stop immediately and the data pipeline flushes, so no stale rgb_valid_o appears.

Test Plan:
1. Reset, then SOF, then bram_en_i held 3 cycles (BRAM_LAT=1): bram_addr_o=0,1,2 with bram_rd_o=1; rgb_o matches BRAM words 0..2 three cycles after each strobe.
2. frame_done_i during frame 0, then next SOF: rd_buf_o=1, swap_ack_o for 1 cycle, first address=291600; last pixel of frame = 583199.
3. frame_done_i in the same cycle as SOF: no swap at that SOF; swap and ack occur at the following SOF.
4. Feed exactly 291600 strobes, then 1 extra: 291600 reads, no read for the extra, ovf_err_o=1; at next SOF unf_err_o stays 0.
5. Frame with 1000 strobes, then SOF: unf_err_o=1, pix_idx restarts, next address=0 (buffer 0).
6. rst_n low mid-frame with reads in flight: next cycle bram_rd_o=0, rgb_valid_o=0, rd_buf_o=0; bram_en_i ignored until the next SOF.
